// File: rtl/note_lane_scroller.sv
// Rhythm-game note lane: streams song ROM codes into a scrolling lane,
// judges hits at a fixed row and keeps combo / hit / miss statistics.
module note_lane_scroller #(
    parameter int ROWS      = 10,
    parameter int CODE_W    = 2,
    parameter int SUB_STEPS = 7,
    parameter int JUDGE_ROW = 1,
    parameter int ADDR_W    = 9,
    parameter int TICK_W    = 17,
    parameter int CNT_W     = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         pause,
    input  logic [ADDR_W-1:0]            song_len,
    input  logic [TICK_W-1:0]            tick_period,
    output logic [ADDR_W-1:0]            rom_addr,
    input  logic [CODE_W-1:0]            rom_data,
    input  logic [(2**CODE_W)-2:0]       hit,
    output logic [ROWS*CODE_W-1:0]       lane,
    output logic [$clog2(SUB_STEPS)-1:0] offset,
    output logic [CNT_W-1:0]             combo,
    output logic [CNT_W-1:0]             max_combo,
    output logic [CNT_W-1:0]             hit_count,
    output logic [CNT_W-1:0]             miss_count,
    output logic                         busy,
    output logic                         finish
);

    localparam int NCOL  = (2**CODE_W) - 1;
    localparam int OFF_W = $clog2(SUB_STEPS);
    localparam int DRN_W = $clog2(ROWS + 1);
    localparam logic [CNT_W-1:0] CMAX = '1;
    localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(SUB_STEPS - 1);
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(ROWS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t              state;
    logic [TICK_W-1:0]   tick_cnt;
    logic [TICK_W-1:0]   tp_q;
    logic [ADDR_W-1:0]   len_q;
    logic [ADDR_W-1:0]   idx;
    logic [DRN_W-1:0]    drn;

    logic                active;
    logic                step;
    logic                shift;
    logic                hit_ok;
    logic                miss;
    logic [CODE_W-1:0]   judge;
    logic [CODE_W-1:0]   entry;
    logic [ROWS*CODE_W-1:0] lane_h;
    logic [ROWS*CODE_W-1:0] lane_n;
    logic [CNT_W-1:0]    combo_inc;

    assign rom_addr = idx;

    // Scroll timing, hit matching and next-lane computation; a hit clears
    // the judge row before any shift so it can never also count as a miss.
    always_comb begin
        active = ((state == RUN) || (state == DRAIN)) && !pause;
        step   = active && (tick_cnt == tp_q);
        shift  = step && (offset == OFF_LAST);
        judge  = lane[JUDGE_ROW*CODE_W +: CODE_W];
        hit_ok = 1'b0;
        for (int c = 0; c < NCOL; c++) begin
            if (hit[c] && (judge == CODE_W'(c + 1))) begin
                hit_ok = 1'b1;
            end
        end
        hit_ok = hit_ok && active;
        lane_h = lane;
        if (hit_ok) begin
            lane_h[JUDGE_ROW*CODE_W +: CODE_W] = '0;
        end
        miss  = shift && (lane_h[JUDGE_ROW*CODE_W +: CODE_W] != '0);
        entry = ((state == RUN) && (idx < len_q)) ? rom_data : '0;
        lane_n = shift ? {entry, lane_h[ROWS*CODE_W-1:CODE_W]} : lane_h;
        combo_inc = (combo == CMAX) ? combo : combo + 1'b1;
    end

    // Song FSM with lane, timing and statistics registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            tp_q       <= '0;
            len_q      <= '0;
            idx        <= '0;
            drn        <= '0;
            lane       <= '0;
            offset     <= '0;
            combo      <= '0;
            max_combo  <= '0;
            hit_count  <= '0;
            miss_count <= '0;
            busy       <= 1'b0;
            finish     <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        tick_cnt   <= '0;
                        tp_q       <= tick_period;
                        len_q      <= song_len;
                        idx        <= '0;
                        drn        <= '0;
                        lane       <= '0;
                        offset     <= '0;
                        combo      <= '0;
                        max_combo  <= '0;
                        hit_count  <= '0;
                        miss_count <= '0;
                        busy       <= 1'b1;
                        finish     <= 1'b0;
                        state      <= (song_len == '0) ? DRAIN : RUN;
                    end
                end
                RUN, DRAIN: begin
                    if (active) begin
                        tick_cnt <= step ? '0 : tick_cnt + 1'b1;
                        if (step) begin
                            offset <= (offset == OFF_LAST) ? '0
                                                           : offset + 1'b1;
                        end
                        lane <= lane_n;
                        if (hit_ok) begin
                            combo <= combo_inc;
                            if (combo_inc > max_combo) begin
                                max_combo <= combo_inc;
                            end
                            if (hit_count != CMAX) begin
                                hit_count <= hit_count + 1'b1;
                            end
                        end
                        if (miss) begin
                            combo <= '0;
                            if (miss_count != CMAX) begin
                                miss_count <= miss_count + 1'b1;
                            end
                        end
                        if (shift && (state == RUN)) begin
                            idx <= idx + 1'b1;
                            if ((idx + 1'b1) == len_q) begin
                                state <= DRAIN;
                            end
                        end
                        if (shift && (state == DRAIN)) begin
                            if (drn == DRN_LAST) begin
                                state  <= DONE;
                                busy   <= 1'b0;
                                finish <= 1'b1;
                            end else begin
                                drn <= drn + 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_note_lane_scroller.sv
// Directed bench for note_lane_scroller: scrolling, judging, pause,
// reset and counter saturation against hand-computed cycle numbers.
module tb_note_lane_scroller;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        pause;
    logic [8:0]  song_len;
    logic [16:0] tick_period;
    logic [8:0]  rom_addr;
    logic [1:0]  rom_data;
    logic [2:0]  hit;
    logic [19:0] lane;
    logic [2:0]  offset;
    logic [7:0]  combo;
    logic [7:0]  max_combo;
    logic [7:0]  hit_count;
    logic [7:0]  miss_count;
    logic        busy;
    logic        finish;

    logic [1:0]  rom [0:511];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;

    note_lane_scroller dut (
        .clk(clk), .rst(rst), .start(start), .pause(pause),
        .song_len(song_len), .tick_period(tick_period),
        .rom_addr(rom_addr), .rom_data(rom_data), .hit(hit),
        .lane(lane), .offset(offset), .combo(combo),
        .max_combo(max_combo), .hit_count(hit_count),
        .miss_count(miss_count), .busy(busy), .finish(finish)
    );

    always #5 clk = ~clk;

    // Edge counter and synchronous song ROM model.
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rom_data <= rom[rom_addr];

    function automatic logic [1:0] row(input int r);
        return lane[r*2 +: 2];
    endfunction

    task automatic wait_to(input int n);
        while (cyc - t0 < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start(input logic [8:0] len, input logic [16:0] tp);
        song_len = len;
        tick_period = tp;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        t0 = cyc;
    endtask

    task automatic load_song(input logic [1:0] a, input logic [1:0] b,
                             input logic [1:0] c, input logic [1:0] d);
        rom[0] = a; rom[1] = b; rom[2] = c; rom[3] = d;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; pause = 1'b0; hit = '0;
        song_len = '0; tick_period = 17'd1;
        for (int i = 0; i < 512; i++) rom[i] = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({lane, offset, rom_addr} !== '0) begin
            errors++;
            $display("FAIL reset_lane: lane=%h off=%0d addr=%0d want 0",
                     lane, offset, rom_addr);
        end
        checks++;
        if ({combo, max_combo, hit_count, miss_count} !== '0) begin
            errors++;
            $display("FAIL reset_cnt: %0d %0d %0d %0d want 0",
                     combo, max_combo, hit_count, miss_count);
        end
        checks++;
        if ({busy, finish} !== 2'b00) begin
            errors++;
            $display("FAIL reset_flags: busy=%b fin=%b want 0",
                     busy, finish);
        end
        rst = 1'b0;
    endtask

    task automatic test_no_hits();
        load_song(2'd1, 2'd2, 2'd1, 2'd0);
        do_start(9'd3, 17'd1);
        checks++;
        if ({busy, finish} !== 2'b10) begin
            errors++;
            $display("FAIL start_flags: busy=%b fin=%b want 1 0",
                     busy, finish);
        end
        wait_to(13);
        checks++;
        if (offset !== 3'd6 || row(9) !== 2'd0) begin
            errors++;
            $display("FAIL pre_shift: off=%0d r9=%0d want 6 0",
                     offset, row(9));
        end
        wait_to(14);
        checks++;
        if (offset !== 3'd0 || row(9) !== 2'd1 || rom_addr !== 9'd1) begin
            errors++;
            $display("FAIL shift1: off=%0d r9=%0d addr=%0d want 0 1 1",
                     offset, row(9), rom_addr);
        end
        wait_to(50);
        song_len = 9'd0;
        start = 1'b1;
        wait_to(51);
        start = 1'b0;
        checks++;
        if ({busy, finish} !== 2'b10 || rom_addr !== 9'd3) begin
            errors++;
            $display("FAIL start_in_run: busy=%b fin=%b addr=%0d want 1 0 3",
                     busy, finish, rom_addr);
        end
        wait_to(126);
        checks++;
        if (row(1) !== 2'd1 || miss_count !== 8'd0) begin
            errors++;
            $display("FAIL at_judge: r1=%0d miss=%0d want 1 0",
                     row(1), miss_count);
        end
        wait_to(140);
        checks++;
        if (miss_count !== 8'd1 || row(0) !== 2'd1) begin
            errors++;
            $display("FAIL miss1: miss=%0d r0=%0d want 1 1",
                     miss_count, row(0));
        end
        wait_to(168);
        checks++;
        if (miss_count !== 8'd3 || combo !== 8'd0) begin
            errors++;
            $display("FAIL miss3: miss=%0d combo=%0d want 3 0",
                     miss_count, combo);
        end
        wait_to(181);
        checks++;
        if (finish !== 1'b0) begin
            errors++;
            $display("FAIL early_finish: fin=%b want 0", finish);
        end
        wait_to(182);
        checks++;
        if ({busy, finish} !== 2'b01 || lane !== '0) begin
            errors++;
            $display("FAIL done13: busy=%b fin=%b lane=%h want 0 1 0",
                     busy, finish, lane);
        end
    endtask

    task automatic test_hits();
        load_song(2'd1, 2'd2, 2'd1, 2'd0);
        do_start(9'd3, 17'd1);
        for (int k = 0; k < 3; k++) begin
            wait_to(126 + 14*k);
            hit = 3'b001 << (rom[k] - 2'd1);
            wait_to(127 + 14*k);
            hit = '0;
            checks++;
            if (row(1) !== 2'd0 || hit_count !== 8'(k + 1)) begin
                errors++;
                $display("FAIL hit%0d: r1=%0d hits=%0d want 0 %0d",
                         k, row(1), hit_count, k + 1);
            end
        end
        wait_to(182);
        checks++;
        if (hit_count !== 8'd3 || combo !== 8'd3 || max_combo !== 8'd3 ||
            miss_count !== 8'd0 || finish !== 1'b1) begin
            errors++;
            $display("FAIL hits_end: h=%0d c=%0d m=%0d x=%0d f=%b want 3 3 3 0 1",
                     hit_count, combo, max_combo, miss_count, finish);
        end
    endtask

    task automatic test_combo();
        load_song(2'd1, 2'd1, 2'd1, 2'd1);
        do_start(9'd4, 17'd1);
        wait_to(126); hit = 3'b001;
        wait_to(127); hit = '0;
        checks++;
        if (combo !== 8'd1) begin
            errors++;
            $display("FAIL combo_a: got %0d want 1", combo);
        end
        wait_to(140); hit = 3'b001;
        wait_to(141); hit = '0;
        checks++;
        if (combo !== 8'd2) begin
            errors++;
            $display("FAIL combo_b: got %0d want 2", combo);
        end
        wait_to(168);
        checks++;
        if (combo !== 8'd0 || miss_count !== 8'd1) begin
            errors++;
            $display("FAIL combo_miss: combo=%0d miss=%0d want 0 1",
                     combo, miss_count);
        end
        hit = 3'b001;
        wait_to(169); hit = '0;
        checks++;
        if (combo !== 8'd1) begin
            errors++;
            $display("FAIL combo_d: got %0d want 1", combo);
        end
        wait_to(196);
        checks++;
        if (max_combo !== 8'd2 || hit_count !== 8'd3 ||
            miss_count !== 8'd1 || finish !== 1'b1) begin
            errors++;
            $display("FAIL combo_end: max=%0d h=%0d x=%0d f=%b want 2 3 1 1",
                     max_combo, hit_count, miss_count, finish);
        end
    endtask

    task automatic test_wrong_colour();
        load_song(2'd1, 2'd2, 2'd1, 2'd0);
        do_start(9'd3, 17'd1);
        wait_to(126); hit = 3'b010;
        wait_to(127); hit = '0;
        checks++;
        if (row(1) !== 2'd1 || hit_count !== 8'd0) begin
            errors++;
            $display("FAIL wrong_col: r1=%0d hits=%0d want 1 0",
                     row(1), hit_count);
        end
        wait_to(140);
        checks++;
        if (miss_count !== 8'd1) begin
            errors++;
            $display("FAIL wrong_miss: miss=%0d want 1", miss_count);
        end
        wait_to(153); hit = 3'b011;
        wait_to(154); hit = '0;
        checks++;
        if (hit_count !== 8'd1 || miss_count !== 8'd1 || combo !== 8'd1 ||
            row(0) !== 2'd0 || row(1) !== 2'd1) begin
            errors++;
            $display("FAIL coincident: h=%0d x=%0d c=%0d r0=%0d r1=%0d want 1 1 1 0 1",
                     hit_count, miss_count, combo, row(0), row(1));
        end
        wait_to(168);
        checks++;
        if (miss_count !== 8'd2 || combo !== 8'd0 || max_combo !== 8'd1) begin
            errors++;
            $display("FAIL after_coinc: x=%0d c=%0d m=%0d want 2 0 1",
                     miss_count, combo, max_combo);
        end
        wait_to(182);
    endtask

    task automatic test_pause();
        load_song(2'd1, 2'd2, 2'd1, 2'd0);
        do_start(9'd3, 17'd1);
        wait_to(21);
        checks++;
        if (offset !== 3'd3) begin
            errors++;
            $display("FAIL pre_pause: off=%0d want 3", offset);
        end
        pause = 1'b1;
        wait_to(71);
        checks++;
        if (offset !== 3'd3 || row(9) !== 2'd1 || row(8) !== 2'd0 ||
            rom_addr !== 9'd1) begin
            errors++;
            $display("FAIL paused: off=%0d r9=%0d r8=%0d addr=%0d want 3 1 0 1",
                     offset, row(9), row(8), rom_addr);
        end
        pause = 1'b0;
        wait_to(72);
        checks++;
        if (offset !== 3'd4) begin
            errors++;
            $display("FAIL resume: off=%0d want 4", offset);
        end
        wait_to(77);
        checks++;
        if (offset !== 3'd6 || row(9) !== 2'd1) begin
            errors++;
            $display("FAIL resume_pre: off=%0d r9=%0d want 6 1",
                     offset, row(9));
        end
        wait_to(78);
        checks++;
        if (offset !== 3'd0 || row(9) !== 2'd2 || row(8) !== 2'd1) begin
            errors++;
            $display("FAIL resume_shift: off=%0d r9=%0d r8=%0d want 0 2 1",
                     offset, row(9), row(8));
        end
    endtask

    task automatic test_rst_mid_run();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({lane, offset, rom_addr, busy, finish} !== '0 ||
            {combo, max_combo, hit_count, miss_count} !== '0) begin
            errors++;
            $display("FAIL async_rst: lane=%h off=%0d addr=%0d busy=%b want 0",
                     lane, offset, rom_addr, busy);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        do_start(9'd0, 17'd1);
        checks++;
        if ({busy, finish} !== 2'b10) begin
            errors++;
            $display("FAIL zero_len_start: busy=%b fin=%b want 1 0",
                     busy, finish);
        end
        wait_to(139);
        checks++;
        if (finish !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_early: fin=%b want 0", finish);
        end
        wait_to(140);
        checks++;
        if (finish !== 1'b1 || busy !== 1'b0 || lane !== '0 ||
            miss_count !== 8'd0) begin
            errors++;
            $display("FAIL zero_len_done: fin=%b busy=%b lane=%h x=%0d want 1 0 0 0",
                     finish, busy, lane, miss_count);
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 260; i++) rom[i] = 2'd1;
        do_start(9'd260, 17'd1);
        hit = 3'b001;
        wait_to(3780);
        hit = '0;
        checks++;
        if (hit_count !== 8'd255 || combo !== 8'd255 ||
            max_combo !== 8'd255 || miss_count !== 8'd0 ||
            finish !== 1'b1) begin
            errors++;
            $display("FAIL sat_hits: h=%0d c=%0d m=%0d x=%0d f=%b want 255 255 255 0 1",
                     hit_count, combo, max_combo, miss_count, finish);
        end
        do_start(9'd260, 17'd1);
        wait_to(3780);
        checks++;
        if (miss_count !== 8'd255 || hit_count !== 8'd0 ||
            combo !== 8'd0 || finish !== 1'b1) begin
            errors++;
            $display("FAIL sat_miss: x=%0d h=%0d c=%0d f=%b want 255 0 0 1",
                     miss_count, hit_count, combo, finish);
        end
    endtask

    initial begin
        test_reset();
        test_no_hits();
        test_hits();
        test_combo();
        test_wrong_colour();
        test_pause();
        test_rst_mid_run();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/note_lane_scroller.md
Name: note_lane_scroller

Overview:
- Parametrised successor of the single-song note shifter for the rhythm game.
- Streams note codes from an external synchronous song ROM into a ROWS-deep visible note lane and scrolls the lane at a programmable tick period with sub-row pixel offset.
- Judges player hits at a fixed judge row for up to 2^CODE_W-1 note colours and keeps combo, max-combo, hit and miss statistics.
- Sits between the song ROM / song selector and the LED-matrix renderer.

Parameters:
ROWS, 10, visible lane depth in note rows; row ROWS-1 is the entry row, row 0 is the exit row
CODE_W, 2, bits per note code; code 0 = empty, codes 1..2^CODE_W-1 = colours
SUB_STEPS, 7, pixel offsets per row; offset counts 0..SUB_STEPS-1
JUDGE_ROW, 1, row checked by hit and miss logic; legal range 0..ROWS-1
ADDR_W, 9, song ROM address width
TICK_W, 17, tick-period counter width
CNT_W, 8, width of combo, max_combo, hit_count and miss_count

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
start  in  1  single-cycle pulse; starts a song from IDLE or DONE
pause  in  1  level; freezes scrolling and judging while high
song_len  in  ADDR_W  number of notes in the song; sampled on start
tick_period  in  TICK_W  clocks per offset step minus 1; sampled on start; must be >=1
rom_addr  out  ADDR_W  song ROM read address
rom_data  in  CODE_W  song ROM data; valid one clock after rom_addr
hit  in  2^CODE_W-1  one pulse per colour; bit c means colour c+1
lane  out  ROWS*CODE_W  row r code at [r*CODE_W +: CODE_W]
offset  out  clog2(SUB_STEPS)  sub-row pixel offset
combo  out  CNT_W  current combo
max_combo  out  CNT_W  best combo of this song
hit_count  out  CNT_W  notes hit
miss_count  out  CNT_W  notes missed
busy  out  1  high in RUN or DRAIN
finish  out  1  high in DONE

Behaviour:
- Reset values:
  - state = IDLE.
  - All outputs = 0, including lane, offset, all counters, rom_addr, busy and finish.
  - Internal tick counter, note index and drain counter = 0.
- States:
  - IDLE: start -> RUN. On the start cycle, clear the lane, offset, all counters and the note index, and latch song_len and tick_period.
  - RUN: when the note index reaches the latched song_len on a row shift -> DRAIN.
  - DRAIN: shift zeros in; after ROWS further row shifts -> DONE.
  - DONE: finish = 1 and all outputs hold. start -> RUN with the same clearing as from IDLE.
- song_len = 0: on start, go directly to DRAIN.
- Tick counter (RUN and DRAIN, pause low):
  - Increments every clock.
  - When it equals the latched tick_period, a step event fires and the counter returns to 0 on the same edge.
- Step event:
  - If offset < SUB_STEPS-1: offset increments.
  - Otherwise: offset returns to 0 and a row shift occurs.
- Row shift:
  - Row r takes the old row r+1 for every r < ROWS-1.
  - Row ROWS-1 takes rom_data if the note index < song_len; otherwise it takes 0.
  - The note index then increments.
- ROM addressing:
  - rom_addr always equals the note index.
  - Because tick_period >= 1, rom_data is valid before any shift.
- Hit judging (RUN or DRAIN, pause low):
  - If hit[c] is set and the judge-row code equals c+1, the judge row clears to 0 and hit_count increments.
  - combo increments; max_combo is updated to max(max_combo, new combo).
  - Hits on an empty or non-matching judge row are ignored, with no penalty.
  - If several hit bits are set, only the matching one acts.
- Miss:
  - Applies on a row shift that occurs while the judge row holds a non-zero code.
  - miss_count increments and combo becomes 0.
- Hit and shift in the same cycle:
  - The hit wins: it counts as a hit.
  - The note is treated as cleared before the shift, so no miss is recorded, and the lower row receives 0.
- All counters saturate at 2^CNT_W-1. Once combo is saturated, further hits leave it saturated.
- pause high:
  - The tick counter, offset, lane, note index and counters hold.
  - hit is ignored.
  - start is still honoured only in IDLE or DONE.
- start during RUN or DRAIN is ignored.
- rst at any time returns to the reset values asynchronously; no partial song state survives.

Test Plan:
- ROWS=10, tick_period=1, song_len=3, ROM = 1,2,1.
  - Start, then no hits.
  - A shift occurs every 14 clocks.
  - 3 misses, combo stays 0, finish asserts after the 13th shift.
- Same song, with hit matching colour pulsed when each note reaches row 1.
  - hit_count=3, combo=3, max_combo=3, miss_count=0.
  - Lane row 1 is 0 the cycle after each hit.
- Notes 1,1,1,1; hit the first two, miss the 3rd, hit the 4th.
  - combo sequence 1,2,0,1; max_combo=2, miss_count=1.
- Hit pulse with wrong colour on an occupied judge row, then a hit coincident with the shift edge.
  - The first pulse is ignored and that note later counts as a miss.
  - The coincident hit counts as a hit with no miss.
- pause held high 50 clocks mid-song.
  - offset, lane and counters are frozen.
  - After release, the shift timing resumes exactly from the paused tick count.
- rst asserted mid-RUN, then start again with song_len=0.
  - All outputs are 0 immediately on rst.
  - The new run reaches DONE after 10 shifts of zeros, with finish=1.
